multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Sequential successor to the single-cycle decode/immediate controller, for a multicycle RV32I/RV64I-subset datapath.
- An FSM sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over a shared instruction/data memory with a ready handshake.
- Width is parametrised by XLEN. ALU control is widened to 3 bits. The immediate is registered at DECODE.
- Sits between the unified memory port and the datapath (PC, IR, register file, ALU).

Parameters:
XLEN, 32, datapath/immediate width (32 or 64)
RESET_TRAP, 0, 1 = illegal-opcode trap is sticky until reset; 0 = TRAP returns to FETCH after one cycle

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
Instruction  input  32  IR contents, valid from DECODE onward
MemReady  input  1  memory completes the current read/write this cycle
Zero  input  1  ALU result == 0 (branch compare)
MemRead  output  1  memory read request (fetch or load)
MemWrite  output  1  memory write request (store)
AddrSrc  output  1  0 = PC addresses memory, 1 = ALU result register
IRWrite  output  1  load IR (and OldPC) from memory data
PCWrite  output  1  update PC this cycle
PCSrc  output  1  0 = PC+4, 1 = OldPC+Imm
RegWrite  output  1  register file write enable
ResultSrc  output  2  00 ALU, 01 memory data, 10 PC (link), 11 Imm (LUI)
ALUSrcB  output  1  0 = rs2, 1 = Imm
ALUControl  output  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL
Imm  output  XLEN  sign-extended immediate, registered in DECODE
Illegal  output  1  unsupported opcode decoded

Behaviour:
- Reset (rst_n=0, async): state=FETCH; Imm=0, Illegal=0. All control outputs derive combinationally from state, so they take FETCH values after reset.
- Reset mid-operation aborts immediately. An in-flight memory request is dropped; the memory side must tolerate this.
- Outputs not listed for a state are 0.
- FETCH: MemRead=1, AddrSrc=0, held until MemReady. On MemReady: IRWrite=1, PCWrite=1, PCSrc=0, next state DECODE. Without MemReady, stay in FETCH (any number of wait cycles).
- DECODE (1 cycle): Imm registered by format.
  - I: Instruction[31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - J: {[31],[19:12],[20],[30:21],0}
  - U: {[31:12],12'b0}
  - All formats sign-extended to XLEN from Instruction[31].
- DECODE next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 / 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 0110111 -> LUI
  - anything else -> TRAP
- EXEC_R: ALUSrcB=0. ALUControl from funct3: 000 ADD (SUB if Instruction[30]), 111 AND, 110 OR, 100 XOR, 010 SLT, 001 SLL, 101 SRL. Next ALU_WB.
- EXEC_I: same as EXEC_R but ALUSrcB=1, and Instruction[30] is ignored for funct3=000. Next ALU_WB.
- ALU_WB: RegWrite=1, ResultSrc=00. Next FETCH.
- MEM_ADDR: ALUSrcB=1, ALUControl=ADD. Next MEM_RD if load, MEM_WR if store.
- MEM_RD: MemRead=1, AddrSrc=1 until MemReady, then MEM_WB.
- MEM_WB: RegWrite=1, ResultSrc=01. Next FETCH.
- MEM_WR: MemWrite=1, AddrSrc=1 until MemReady, then FETCH.
- BRANCH: ALUControl=SUB, PCSrc=1, PCWrite = Zero XOR funct3[0] (BEQ/BNE only). Any other funct3 -> TRAP. Next FETCH.
- JAL: RegWrite=1, ResultSrc=10 (PC already +4), PCWrite=1, PCSrc=1. Next FETCH.
- LUI: RegWrite=1, ResultSrc=11. Next FETCH.
- TRAP: Illegal=1.
  - RESET_TRAP=1: remain in TRAP, Illegal held, until reset.
  - RESET_TRAP=0: Illegal pulses 1 cycle, PCWrite=0, next FETCH.
- Latency in clocks (zero wait states): R/I 4, load 5, store 4, branch 3, JAL 3, LUI 3. Each wait state on MemReady adds one cycle.

Optional Feature:
- Macro INSTRET_COUNTER_EN.
- Defined: adds output InstRet [63:0]. Reset 0. Increments by 1 on every transition into FETCH from a non-FETCH state, except from TRAP. Wraps modulo 2^64.
- Not defined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- add x3,x1,x2 (0x002081B3), MemReady=1 in FETCH -> FETCH,DECODE,EXEC_R(ALUControl=000),ALU_WB(RegWrite=1,ResultSrc=00); 4 cycles total.
- lw x5,8(x0) (0x00802283) with 2 wait states on each access -> Imm=8; MEM_RD holds MemRead=1, AddrSrc=1 for 3 cycles; MEM_WB RegWrite=1, ResultSrc=01; 9 cycles total.
- sw x5,12(x0) (0x00502623) -> Imm=12 (S-format); MEM_WR MemWrite=1 until MemReady; RegWrite never asserted.
- beq x0,x0,-8 (0xFE000CE3), Zero=1 -> Imm=0xFFFFFFF8 (XLEN=32) / 0xFFFFFFFFFFFFFFF8 (XLEN=64); BRANCH PCWrite=1, PCSrc=1. Repeat with Zero=0 -> PCWrite=0.
- 0xFFFFFFFF with RESET_TRAP=1 -> Illegal=1 held for 10+ cycles, no MemRead. rst_n low mid-wait -> Illegal=0, MemRead=1 (FETCH) immediately.
- INSTRET_COUNTER_EN: three back-to-back instructions -> InstRet=3; illegal instruction with RESET_TRAP=0 -> InstRet unchanged.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RV32I/RV64I-subset controller: FSM over a shared memory port with a ready handshake.
// Define INSTRET_COUNTER_EN to add the 64-bit retired-instruction counter output InstRet.
module multicycle_controller #(
  parameter int unsigned XLEN       = 32,
  parameter bit          RESET_TRAP = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     Instruction,
  input  logic            MemReady,
  input  logic            Zero,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            AddrSrc,
  output logic            IRWrite,
  output logic            PCWrite,
  output logic            PCSrc,
  output logic            RegWrite,
  output logic [1:0]      ResultSrc,
  output logic            ALUSrcB,
  output logic [2:0]      ALUControl,
  output logic [XLEN-1:0] Imm,
  output logic            Illegal
`ifdef INSTRET_COUNTER_EN
  ,
  output logic [63:0]     InstRet
`endif
);

  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  typedef enum logic [3:0] {
    StFetch, StDecode, StExecR, StExecI, StAluWb, StMemAddr, StMemRd,
    StMemWb, StMemWr, StBranch, StJal, StLui, StTrap
  } state_e;

  state_e          r_state, w_next;
  logic [XLEN-1:0] r_imm, w_imm;
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;

  assign w_opcode = Instruction[6:0];
  assign w_funct3 = Instruction[14:12];
  assign Imm      = r_imm;

  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? 3'b001 : 3'b000;
      3'b111:  return 3'b010;
      3'b110:  return 3'b011;
      3'b100:  return 3'b100;
      3'b010:  return 3'b101;
      3'b001:  return 3'b110;
      3'b101:  return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // Every format sign-extends from Instruction[31]; I-format covers loads and unknown opcodes.
  always_comb begin
    case (w_opcode)
      OpStore:  w_imm = XLEN'($signed({Instruction[31:25], Instruction[11:7]}));
      OpBranch: w_imm = XLEN'($signed({Instruction[31], Instruction[7], Instruction[30:25],
                                       Instruction[11:8], 1'b0}));
      OpJal:    w_imm = XLEN'($signed({Instruction[31], Instruction[19:12], Instruction[20],
                                       Instruction[30:21], 1'b0}));
      OpLui:    w_imm = XLEN'($signed({Instruction[31:12], 12'b0}));
      default:  w_imm = XLEN'($signed(Instruction[31:20]));
    endcase
  end

  always_comb begin
    w_next     = r_state;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    AddrSrc    = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcB    = 1'b0;
    ALUControl = 3'b000;
    Illegal    = 1'b0;
    unique case (r_state)
      StFetch: begin
        MemRead = 1'b1;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          w_next  = StDecode;
        end
      end
      StDecode: begin
        case (w_opcode)
          OpRType:         w_next = StExecR;
          OpIType:         w_next = StExecI;
          OpLoad, OpStore: w_next = StMemAddr;
          OpBranch:        w_next = StBranch;
          OpJal:           w_next = StJal;
          OpLui:           w_next = StLui;
          default:         w_next = StTrap;
        endcase
      end
      StExecR: begin
        ALUControl = alu_dec(w_funct3, Instruction[30]);
        w_next     = StAluWb;
      end
      StExecI: begin
        ALUSrcB    = 1'b1;
        ALUControl = alu_dec(w_funct3, 1'b0);
        w_next     = StAluWb;
      end
      StAluWb: begin
        RegWrite = 1'b1;
        w_next   = StFetch;
      end
      StMemAddr: begin
        ALUSrcB = 1'b1;
        w_next  = w_opcode[5] ? StMemWr : StMemRd;
      end
      StMemRd: begin
        MemRead = 1'b1;
        AddrSrc = 1'b1;
        if (MemReady) w_next = StMemWb;
      end
      StMemWb: begin
        RegWrite  = 1'b1;
        ResultSrc = 2'b01;
        w_next    = StFetch;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        AddrSrc  = 1'b1;
        if (MemReady) w_next = StFetch;
      end
      StBranch: begin
        ALUControl = 3'b001;
        PCSrc      = 1'b1;
        // Only BEQ/BNE exist; funct3[0] inverts the equality test.
        if (w_funct3[2:1] == 2'b00) begin
          PCWrite = Zero ^ w_funct3[0];
          w_next  = StFetch;
        end else begin
          w_next = StTrap;
        end
      end
      StJal: begin
        RegWrite  = 1'b1;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
        PCSrc     = 1'b1;
        w_next    = StFetch;
      end
      StLui: begin
        RegWrite  = 1'b1;
        ResultSrc = 2'b11;
        w_next    = StFetch;
      end
      StTrap: begin
        Illegal = 1'b1;
        w_next  = RESET_TRAP ? StTrap : StFetch;
      end
      default: w_next = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StFetch;
      r_imm   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == StDecode) r_imm <= w_imm;
    end
  end

`ifdef INSTRET_COUNTER_EN
  logic [63:0] r_instret;
  assign InstRet = r_instret;

  // Trap exits re-enter FETCH without retiring anything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= '0;
    end else if (w_next == StFetch && r_state != StFetch && r_state != StTrap) begin
      r_instret <= r_instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: per-cycle expected control words are queued, then popped against the DUT.
module tb_multicycle_controller;

  localparam int unsigned XLEN = 32;

  // Control word: MemRead MemWrite AddrSrc IRWrite PCWrite PCSrc RegWrite ResultSrc ALUSrcB ALUCtl Ill
  localparam logic [13:0] CtlFetchWait = 14'b1_0_0_0_0_0_0_00_0_000_0;
  localparam logic [13:0] CtlFetchRdy  = 14'b1_0_0_1_1_0_0_00_0_000_0;
  localparam logic [13:0] CtlDecode    = 14'b0_0_0_0_0_0_0_00_0_000_0;
  localparam logic [13:0] CtlAluWb     = 14'b0_0_0_0_0_0_1_00_0_000_0;
  localparam logic [13:0] CtlMemAddr   = 14'b0_0_0_0_0_0_0_00_1_000_0;
  localparam logic [13:0] CtlMemRd     = 14'b1_0_1_0_0_0_0_00_0_000_0;
  localparam logic [13:0] CtlMemWb     = 14'b0_0_0_0_0_0_1_01_0_000_0;
  localparam logic [13:0] CtlMemWr     = 14'b0_1_1_0_0_0_0_00_0_000_0;
  localparam logic [13:0] CtlJal       = 14'b0_0_0_0_1_1_1_10_0_000_0;
  localparam logic [13:0] CtlLui       = 14'b0_0_0_0_0_0_1_11_0_000_0;
  localparam logic [13:0] CtlTrap      = 14'b0_0_0_0_0_0_0_00_0_000_1;

  typedef struct packed {
    logic [31:0] instr;
    logic        ready;
    logic        zero;
    logic [13:0] ctl;
  } step_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [31:0]     Instruction;
  logic            MemReady;
  logic            Zero;

  logic            mem_read_a, mem_write_a, addr_src_a, ir_write_a, pc_write_a, pc_src_a;
  logic            reg_write_a, alu_src_b_a, illegal_a;
  logic [1:0]      result_src_a;
  logic [2:0]      alu_ctl_a;
  logic [XLEN-1:0] imm_a;
  logic            mem_read_b, mem_write_b, addr_src_b, ir_write_b, pc_write_b, pc_src_b;
  logic            reg_write_b, alu_src_b_b, illegal_b;
  logic [1:0]      result_src_b;
  logic [2:0]      alu_ctl_b;
  logic [XLEN-1:0] imm_b;
`ifdef INSTRET_COUNTER_EN
  logic [63:0]     instret_a, instret_b;
  logic [63:0]     instret_mark;
`endif

  logic [13:0] ctl_a, ctl_b;
  assign ctl_a = {mem_read_a, mem_write_a, addr_src_a, ir_write_a, pc_write_a, pc_src_a,
                  reg_write_a, result_src_a, alu_src_b_a, alu_ctl_a, illegal_a};
  assign ctl_b = {mem_read_b, mem_write_b, addr_src_b, ir_write_b, pc_write_b, pc_src_b,
                  reg_write_b, result_src_b, alu_src_b_b, alu_ctl_b, illegal_b};

  step_t       sb[$];
  logic [31:0] cur_instr;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.XLEN(XLEN), .RESET_TRAP(1'b0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .Instruction(Instruction), .MemReady(MemReady), .Zero(Zero),
    .MemRead(mem_read_a), .MemWrite(mem_write_a), .AddrSrc(addr_src_a), .IRWrite(ir_write_a),
    .PCWrite(pc_write_a), .PCSrc(pc_src_a), .RegWrite(reg_write_a), .ResultSrc(result_src_a),
    .ALUSrcB(alu_src_b_a), .ALUControl(alu_ctl_a), .Imm(imm_a), .Illegal(illegal_a)
`ifdef INSTRET_COUNTER_EN
    , .InstRet(instret_a)
`endif
  );

  multicycle_controller #(.XLEN(XLEN), .RESET_TRAP(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .Instruction(Instruction), .MemReady(MemReady), .Zero(Zero),
    .MemRead(mem_read_b), .MemWrite(mem_write_b), .AddrSrc(addr_src_b), .IRWrite(ir_write_b),
    .PCWrite(pc_write_b), .PCSrc(pc_src_b), .RegWrite(reg_write_b), .ResultSrc(result_src_b),
    .ALUSrcB(alu_src_b_b), .ALUControl(alu_ctl_b), .Imm(imm_b), .Illegal(illegal_b)
`ifdef INSTRET_COUNTER_EN
    , .InstRet(instret_b)
`endif
  );

  function automatic logic [13:0] ctl_exec(input logic bsrc, input logic [2:0] alu);
    return {7'b0000000, 2'b00, bsrc, alu, 1'b0};
  endfunction

  function automatic logic [13:0] ctl_branch(input logic pcw);
    return {4'b0000, pcw, 1'b1, 1'b0, 2'b00, 1'b0, 3'b001, 1'b0};
  endfunction

  task automatic push(input logic [13:0] ctl, input logic ready = 1'b0,
                      input logic zero = 1'b0);
    step_t s;
    s.instr = cur_instr;
    s.ready = ready;
    s.zero  = zero;
    s.ctl   = ctl;
    sb.push_back(s);
  endtask

  task automatic push_fetch(input int waits);
    for (int i = 0; i < waits; i++) push(CtlFetchWait);
    push(CtlFetchRdy, 1'b1);
  endtask

  // Drive one cycle's inputs just after the rising edge and stop at the falling edge.
  task automatic play(input step_t s);
    Instruction = s.instr;
    MemReady    = s.ready;
    Zero        = s.zero;
    @(negedge clk);
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    Instruction = 32'h0;
    MemReady    = 1'b0;
    Zero        = 1'b0;
    cur_instr   = 32'h0;
    #12;
    n_tests++;
    if (ctl_a !== CtlFetchWait) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want %b", ctl_a, CtlFetchWait);
    end
    n_tests++;
    if (imm_a !== '0) begin
      n_fail++;
      $display("FAIL reset_imm: got %h want 0", imm_a);
    end
`ifdef INSTRET_COUNTER_EN
    n_tests++;
    if (instret_a !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_instret: got %0d want 0", instret_a);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    next_edge();
  endtask

  task automatic test_r_type();
    logic [31:0] instrs [8] = '{32'h002081B3, 32'h0020F1B3, 32'h0020E1B3, 32'h0020C1B3,
                                32'h0020A1B3, 32'h002091B3, 32'h0020D1B3, 32'h402081B3};
    logic [2:0]  alus   [8] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b001};
    step_t s;
    for (int i = 0; i < 8; i++) begin
      int k = 0;
      cur_instr = instrs[i];
      push_fetch(0);
      push(CtlDecode);
      push(ctl_exec(1'b0, alus[i]));
      push(CtlAluWb);
      push(CtlFetchWait);
      while (sb.size() != 0) begin
        s = sb.pop_front();
        play(s);
        n_tests++;
        if (ctl_a !== s.ctl) begin
          n_fail++;
          $display("FAIL r_type %h step %0d: got %b want %b", instrs[i], k, ctl_a, s.ctl);
        end
        next_edge();
        k++;
      end
    end
  endtask

  task automatic test_i_type();
    logic [31:0] instrs [2] = '{32'hFFF08093, 32'h0FF0F093};
    logic [2:0]  alus   [2] = '{3'b000, 3'b010};
    logic [63:0] imms   [2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_00FF};
    step_t s;
    for (int i = 0; i < 2; i++) begin
      int k = 0;
      cur_instr = instrs[i];
      push_fetch(0);
      push(CtlDecode);
      push(ctl_exec(1'b1, alus[i]));
      push(CtlAluWb);
      push(CtlFetchWait);
      while (sb.size() != 0) begin
        s = sb.pop_front();
        play(s);
        n_tests++;
        if (ctl_a !== s.ctl) begin
          n_fail++;
          $display("FAIL i_type %h step %0d: got %b want %b", instrs[i], k, ctl_a, s.ctl);
        end
        next_edge();
        k++;
      end
      n_tests++;
      if (imm_a !== imms[i][XLEN-1:0]) begin
        n_fail++;
        $display("FAIL i_type_imm %h: got %h want %h", instrs[i], imm_a, imms[i][XLEN-1:0]);
      end
    end
  endtask

  task automatic test_load();
    step_t s;
    int k = 0;
    cur_instr = 32'h00802283;
    push_fetch(2);
    push(CtlDecode);
    push(CtlMemAddr);
    push(CtlMemRd);
    push(CtlMemRd);
    push(CtlMemRd, 1'b1);
    push(CtlMemWb);
    push(CtlFetchWait);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      play(s);
      n_tests++;
      if (ctl_a !== s.ctl) begin
        n_fail++;
        $display("FAIL load step %0d: got %b want %b", k, ctl_a, s.ctl);
      end
      next_edge();
      k++;
    end
    n_tests++;
    if (imm_a !== XLEN'(64'd8)) begin
      n_fail++;
      $display("FAIL load_imm: got %h want 8", imm_a);
    end
  endtask

  task automatic test_store();
    step_t s;
    int k = 0;
    cur_instr = 32'h00502623;
    push_fetch(0);
    push(CtlDecode);
    push(CtlMemAddr);
    push(CtlMemWr);
    push(CtlMemWr, 1'b1);
    push(CtlFetchWait);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      play(s);
      n_tests++;
      if (ctl_a !== s.ctl) begin
        n_fail++;
        $display("FAIL store step %0d: got %b want %b", k, ctl_a, s.ctl);
      end
      next_edge();
      k++;
    end
    n_tests++;
    if (imm_a !== XLEN'(64'd12)) begin
      n_fail++;
      $display("FAIL store_imm: got %h want c", imm_a);
    end
  endtask

  task automatic test_branch();
    logic [31:0] instrs [4] = '{32'hFE000CE3, 32'hFE000CE3, 32'hFE001CE3, 32'hFE001CE3};
    logic        zeros  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        pcws   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [63:0] exp_imm = 64'hFFFF_FFFF_FFFF_FFF8;
    step_t s;
    for (int i = 0; i < 4; i++) begin
      int k = 0;
      cur_instr = instrs[i];
      push_fetch(0);
      push(CtlDecode);
      push(ctl_branch(pcws[i]), 1'b0, zeros[i]);
      push(CtlFetchWait);
      while (sb.size() != 0) begin
        s = sb.pop_front();
        play(s);
        n_tests++;
        if (ctl_a !== s.ctl) begin
          n_fail++;
          $display("FAIL branch %h zero=%0b step %0d: got %b want %b", instrs[i], zeros[i], k,
                   ctl_a, s.ctl);
        end
        next_edge();
        k++;
      end
      n_tests++;
      if (imm_a !== exp_imm[XLEN-1:0]) begin
        n_fail++;
        $display("FAIL branch_imm: got %h want %h", imm_a, exp_imm[XLEN-1:0]);
      end
    end
  endtask

  // add, jal, lui with no idle cycle between them.
  task automatic test_back_to_back();
    step_t s;
    int k = 0;
`ifdef INSTRET_COUNTER_EN
    instret_mark = instret_a;
`endif
    cur_instr = 32'h002081B3;
    push_fetch(0);
    push(CtlDecode);
    push(ctl_exec(1'b0, 3'b000));
    push(CtlAluWb);
    cur_instr = 32'h008000EF;
    push_fetch(0);
    push(CtlDecode);
    push(CtlJal);
    cur_instr = 32'h123452B7;
    push_fetch(0);
    push(CtlDecode);
    push(CtlLui);
    push(CtlFetchWait);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      play(s);
      n_tests++;
      if (ctl_a !== s.ctl) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: got %b want %b", k, ctl_a, s.ctl);
      end
      next_edge();
      k++;
    end
    n_tests++;
    if (imm_a !== XLEN'(64'h12345000)) begin
      n_fail++;
      $display("FAIL lui_imm: got %h want 12345000", imm_a);
    end
`ifdef INSTRET_COUNTER_EN
    n_tests++;
    if (instret_a !== instret_mark + 64'd3) begin
      n_fail++;
      $display("FAIL instret_b2b: got %0d want %0d", instret_a, instret_mark + 64'd3);
    end
`endif
  endtask

  task automatic test_trap();
    step_t s;
    int k = 0;
`ifdef INSTRET_COUNTER_EN
    instret_mark = instret_a;
`endif
    cur_instr = 32'hFFFFFFFF;
    push_fetch(0);
    push(CtlDecode);
    push(CtlTrap);
    push(CtlFetchWait);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      play(s);
      n_tests++;
      if (ctl_a !== s.ctl) begin
        n_fail++;
        $display("FAIL trap_a step %0d: got %b want %b", k, ctl_a, s.ctl);
      end
      if (k < 3) begin
        n_tests++;
        if (ctl_b !== s.ctl) begin
          n_fail++;
          $display("FAIL trap_b step %0d: got %b want %b", k, ctl_b, s.ctl);
        end
      end
      next_edge();
      k++;
    end
    MemReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if (illegal_b !== 1'b1 || mem_read_b !== 1'b0) begin
        n_fail++;
        $display("FAIL sticky_trap cycle %0d: Illegal=%b MemRead=%b want 1/0", i, illegal_b,
                 mem_read_b);
      end
      next_edge();
    end
`ifdef INSTRET_COUNTER_EN
    n_tests++;
    if (instret_a !== instret_mark) begin
      n_fail++;
      $display("FAIL instret_trap: got %0d want %0d", instret_a, instret_mark);
    end
`endif
    // Asynchronous reset between clock edges while sticky-trapped.
    MemReady = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (illegal_b !== 1'b0 || mem_read_b !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: Illegal=%b MemRead=%b want 0/1", illegal_b, mem_read_b);
    end
    n_tests++;
    if (imm_a !== '0 || ctl_a !== CtlFetchWait) begin
      n_fail++;
      $display("FAIL async_reset_a: imm=%h ctl=%b want 0/%b", imm_a, ctl_a, CtlFetchWait);
    end
    #1;
    rst_n = 1'b1;
    next_edge();
  endtask

  // Unsupported branch funct3 runs BRANCH without writing PC, then traps.
  task automatic test_bad_branch();
    step_t s;
    int k = 0;
`ifdef INSTRET_COUNTER_EN
    instret_mark = instret_a;
`endif
    cur_instr = 32'hFE002CE3;
    push_fetch(0);
    push(CtlDecode);
    push(ctl_branch(1'b0), 1'b0, 1'b1);
    push(CtlTrap);
    push(CtlFetchWait);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      play(s);
      n_tests++;
      if (ctl_a !== s.ctl) begin
        n_fail++;
        $display("FAIL bad_branch step %0d: got %b want %b", k, ctl_a, s.ctl);
      end
      next_edge();
      k++;
    end
`ifdef INSTRET_COUNTER_EN
    n_tests++;
    if (instret_a !== instret_mark) begin
      n_fail++;
      $display("FAIL instret_bad_branch: got %0d want %0d", instret_a, instret_mark);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_i_type();
    test_load();
    test_store();
    test_branch();
    test_back_to_back();
    test_trap();
    test_bad_branch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
